pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised program-counter sequencer for the fetch stage. It replaces the single-mode next-PC register with a start/run/done control FSM, conditional relative and absolute branches, stall, and a hardware return-address stack for call/return. Its output `prog_ctr` drives the instruction-memory address directly.

## Interface
- `D`, 9: PC / address width in bits.
- `DEPTH`, 4: return-stack entries (≥1).
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `start`  in  1  load `start_addr`, clear stack and error, enter RUN.
- `start_addr`  in  D  program entry address.
- `stall`  in  1  hold all RUN state this cycle.
- `taken`  in  1  branch condition; qualifies `br_rel` and `br_abs`.
- `br_rel`  in  1  relative branch; `target` is a two's-complement offset.
- `br_abs`  in  1  absolute branch; `target` is the address.
- `call`  in  1  push `prog_ctr+1`, jump to `target` (absolute, unconditional).
- `ret`  in  1  pop the stack into `prog_ctr`.
- `halt`  in  1  stop execution.
- `target`  in  D  offset or address.
- `prog_ctr`  out  D  current PC.
- `running`  out  1  state == RUN.
- `done`  out  1  state == DONE.
- `stack_err`  out  1  sticky overflow/underflow flag.
- `stack_depth`  out  $clog2(DEPTH+1)  occupied entries.

## Operation
- FSM states: IDLE, RUN, DONE.
- Reset: state IDLE, `prog_ctr`=0, stack empty, `stack_depth`=0, `stack_err`=0, `running`=0, `done`=0.
- `start`=1 in any state (reset excepted) → `prog_ctr`←`start_addr`, stack emptied, `stack_err`←0, state RUN. Start has priority over every other input except reset.
- IDLE and DONE: PC and stack hold; all inputs other than `start` are ignored.
- RUN, `stall`=1: everything holds; control inputs are ignored.
- RUN, `stall`=0, priority is highest first:
  - `halt` → DONE; PC holds.
  - `ret`:
    - stack empty → `stack_err`←1, DONE, PC holds.
    - otherwise → PC←top entry, depth−1.
  - `call`:
    - stack full → `stack_err`←1, DONE, PC holds.
    - otherwise → push PC+1, PC←`target`, depth+1.
  - `br_abs`&`taken` → PC←`target`.
  - `br_rel`&`taken` → PC←PC+sext(`target`).
  - else → PC←PC+1.
- Arithmetic: all PC math is modulo 2^D. PC+1 at 2^D−1 wraps to 0. A relative branch that crosses 0 or 2^D−1 wraps silently. The pushed value PC+1 wraps the same way.
- A `br_*` with `taken`=0 is a plain increment.

## Timing
- Single-cycle: controls sampled at edge N take effect in `prog_ctr` after edge N; there are no bubbles.
- `running`, `done` and `stack_depth` are decoded from registered state. `stack_err` is a register. All outputs are glitch-free from flops.
- A call followed immediately by a ret on the next cycle returns the call address +1 with no hazard.
- Push and pop never occur in the same cycle (priority rule).
- `reset` asserted mid-program forces the reset values at the next edge, regardless of `stall` or `start`.

## Structure
- Package `pc_seq_pkg` holds:
  - the state enum `pc_state_t` {IDLE, RUN, DONE};
  - the command-priority encoding `pc_cmd_t` {CMD_HOLD, CMD_HALT, CMD_RET, CMD_CALL, CMD_ABS, CMD_REL, CMD_INC}, used by RTL and bench coverage.
- Sub-module `ret_stack #(D, DEPTH)`: a LIFO with `push`, `pop`, `clear`, `wdata`, `rdata` (top, combinational), `full`, `empty` and `depth`. It uses a register array plus a pointer and has a synchronous clear.
- The top level holds the FSM, the priority decode and the PC register.

## Test plan
1. `reset`, then `start` with `start_addr`=0x010, with no controls for 3 cycles → PC 0x010, 0x011, 0x012, 0x013; `running`=1.
2. PC=0x020, `br_rel`=1, `taken`=1, `target`=0x1FC (−4) → PC 0x01C. Repeat with `taken`=0 → 0x021. PC=0x1FF with no controls → wraps to 0x000.
3. Calls and returns, DEPTH=4:
   - Call from 0x030 to 0x100 → `stack_depth`=1.
   - Call from 0x105 to 0x180 → depth 2.
   - Ret → PC 0x106.
   - Ret → PC 0x031, depth 0.
4. Fill 4 calls, then a 5th call → `stack_err`=1, `done`=1, PC unchanged, depth 4. Then `start` → err 0, depth 0, RUN.
5. Ret with the stack empty → `stack_err`=1, DONE. Separately: `stall`=1 together with `call` for 2 cycles → PC, depth and state unchanged.
6. `halt` and `ret` asserted together → DONE with PC held. Then `reset` mid-RUN while `stall`=1 → PC 0, IDLE, depth 0.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared state and command encodings for the PC sequencer
package pc_seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} pc_state_t;
  typedef enum logic [2:0] {CMD_HOLD, CMD_HALT, CMD_RET, CMD_CALL, CMD_ABS, CMD_REL, CMD_INC} pc_cmd_t;
endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// ret_stack: return-address LIFO with combinational top-of-stack and synchronous clear
module ret_stack #(
  parameter int D = 9,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         push,
  input  logic                         pop,
  input  logic [D-1:0]                 wdata,
  output logic [D-1:0]                 rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   depth
);
  localparam int PW = $clog2(DEPTH + 1);
  logic [D-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_ptr;
  assign full  = r_ptr == PW'(DEPTH);
  assign empty = r_ptr == '0;
  assign depth = r_ptr;
  // top entry sits just below the pointer; reads zero when empty
  always_comb begin
    rdata = '0;
    for (int i = 0; i < DEPTH; i++) if (r_ptr == PW'(i + 1)) rdata = r_mem[i];
  end
  // pointer moves on accepted push/pop; clear and reset empty the stack
  always_ff @(posedge clk) begin
    if (reset || clear) r_ptr <= '0;
    else if (push && !full) r_ptr <= r_ptr + PW'(1);
    else if (pop && !empty) r_ptr <= r_ptr - PW'(1);
  end
  // write the pushed address into the slot the pointer names
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) if (push && !full && !clear && !reset && r_ptr == PW'(i)) r_mem[i] <= wdata;
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage PC with start/run/done FSM, branches, stall and call/return stack
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int D = 9,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [D-1:0]                 start_addr,
  input  logic                         stall,
  input  logic                         taken,
  input  logic                         br_rel,
  input  logic                         br_abs,
  input  logic                         call,
  input  logic                         ret,
  input  logic                         halt,
  input  logic [D-1:0]                 target,
  output logic [D-1:0]                 prog_ctr,
  output logic                         running,
  output logic                         done,
  output logic                         stack_err,
  output logic [$clog2(DEPTH+1)-1:0]   stack_depth
);
  pc_state_t    r_state, w_state;
  pc_cmd_t      w_cmd;
  logic [D-1:0] r_pc, w_pc, w_top, w_inc;
  logic         r_err, w_full, w_empty, w_push, w_pop, w_err_set;
  assign w_inc = r_pc + D'(1);
  ret_stack #(.D(D), .DEPTH(DEPTH)) u_stack (
    .clk(clk), .reset(reset), .clear(start), .push(w_push), .pop(w_pop), .wdata(w_inc),
    .rdata(w_top), .full(w_full), .empty(w_empty), .depth(stack_depth)
  );
  // priority decode of this cycle's command, next state and next PC
  always_comb begin
    w_cmd = CMD_HOLD;
    if (r_state == RUN && !stall)
      w_cmd = halt ? CMD_HALT : ret ? CMD_RET : call ? CMD_CALL :
              (br_abs && taken) ? CMD_ABS : (br_rel && taken) ? CMD_REL : CMD_INC;
    w_err_set = (w_cmd == CMD_RET && w_empty) || (w_cmd == CMD_CALL && w_full);
    w_push = !start && w_cmd == CMD_CALL && !w_full;
    w_pop = !start && w_cmd == CMD_RET && !w_empty;
    w_state = start ? RUN : (w_cmd == CMD_HALT || w_err_set) ? DONE : r_state;
    w_pc = start ? start_addr : w_pop ? w_top : w_push ? target :
           w_cmd == CMD_ABS ? target : w_cmd == CMD_REL ? r_pc + target :
           w_cmd == CMD_INC ? w_inc : r_pc;
  end
  // state, PC and sticky stack error registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_pc <= '0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_state;
      r_pc <= w_pc;
      r_err <= start ? 1'b0 : (r_err || w_err_set);
    end
  end
  assign prog_ctr  = r_pc;
  assign running   = r_state == RUN;
  assign done      = r_state == DONE;
  assign stack_err = r_err;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed plan plus random stimulus against a queue-based reference model
module tb_pc_sequencer;
  localparam int D = 9, DEPTH = 4, DW = $clog2(DEPTH + 1), MOD = 1 << D;
  logic clk = 0, reset, start, stall, taken, br_rel, br_abs, call, ret, halt;
  logic [D-1:0] start_addr, target, prog_ctr;
  logic running, done, stack_err;
  logic [DW-1:0] stack_depth;
  int n_cmp = 0, n_mis = 0;
  int m_pc = 0, m_st = 0, m_err = 0;
  int m_stk[$];
  always #5 clk = ~clk;
  pc_sequencer #(.D(D), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .stall(stall),
    .taken(taken), .br_rel(br_rel), .br_abs(br_abs), .call(call), .ret(ret), .halt(halt),
    .target(target), .prog_ctr(prog_ctr), .running(running), .done(done),
    .stack_err(stack_err), .stack_depth(stack_depth)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic clr();
    {reset, start, stall, taken, br_rel, br_abs, call, ret, halt} = '0;
    start_addr = '0;
    target = '0;
  endtask
  // reference: states 0 idle, 1 run, 2 done; stack is a queue of return addresses
  task automatic model();
    int off;
    if (reset) begin
      m_pc = 0; m_st = 0; m_err = 0; m_stk.delete();
    end else if (start) begin
      m_pc = int'(start_addr); m_st = 1; m_err = 0; m_stk.delete();
    end else if (m_st == 1 && !stall) begin
      if (halt) m_st = 2;
      else if (ret) begin
        if (m_stk.size() == 0) begin m_err = 1; m_st = 2; end
        else m_pc = m_stk.pop_back();
      end else if (call) begin
        if (m_stk.size() == DEPTH) begin m_err = 1; m_st = 2; end
        else begin m_stk.push_back((m_pc + 1) % MOD); m_pc = int'(target); end
      end else if (br_abs && taken) m_pc = int'(target);
      else if (br_rel && taken) begin
        off = int'(target) >= MOD / 2 ? int'(target) - MOD : int'(target);
        m_pc = ((m_pc + off) % MOD + MOD) % MOD;
      end else m_pc = (m_pc + 1) % MOD;
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model();
    #1;
    check("pc", prog_ctr, m_pc);
    check("running", running, m_st == 1);
    check("done", done, m_st == 2);
    check("stack_err", stack_err, m_err);
    check("depth", stack_depth, m_stk.size());
  endtask
  initial begin
    clr();
    reset = 1;
    tick();
    check("rst_pc", prog_ctr, 0);
    check("rst_run", running, 0);
    reset = 0;
    start = 1; start_addr = 9'h010; tick(); start = 0;
    check("t1_pc0", prog_ctr, 9'h010);
    repeat (3) tick();
    check("t1_pc3", prog_ctr, 9'h013);
    check("t1_run", running, 1);
    start = 1; start_addr = 9'h020; tick(); start = 0;
    br_rel = 1; taken = 1; target = 9'h1FC; tick();
    check("t2_rel", prog_ctr, 9'h01C);
    start = 1; tick(); start = 0;
    taken = 0; tick();
    check("t2_nt", prog_ctr, 9'h021);
    br_rel = 0;
    start = 1; start_addr = 9'h1FF; tick(); start = 0;
    tick();
    check("t2_wrap", prog_ctr, 9'h000);
    start = 1; start_addr = 9'h030; tick(); start = 0;
    call = 1; target = 9'h100; tick(); call = 0;
    check("t3_c1", prog_ctr, 9'h100);
    check("t3_d1", stack_depth, 1);
    repeat (5) tick();
    call = 1; target = 9'h180; tick(); call = 0;
    check("t3_d2", stack_depth, 2);
    ret = 1; tick();
    check("t3_r1", prog_ctr, 9'h106);
    tick(); ret = 0;
    check("t3_r2", prog_ctr, 9'h031);
    check("t3_d0", stack_depth, 0);
    start = 1; start_addr = 9'h000; tick(); start = 0;
    call = 1; target = 9'h040;
    repeat (4) tick();
    check("t4_full", stack_depth, 4);
    tick(); call = 0;
    check("t4_err", stack_err, 1);
    check("t4_done", done, 1);
    check("t4_pc", prog_ctr, 9'h040);
    check("t4_depth", stack_depth, 4);
    start = 1; start_addr = 9'h055; tick(); start = 0;
    check("t4_clr_err", stack_err, 0);
    check("t4_clr_d", stack_depth, 0);
    check("t4_run", running, 1);
    ret = 1; tick(); ret = 0;
    check("t5_uerr", stack_err, 1);
    check("t5_done", done, 1);
    start = 1; start_addr = 9'h0A0; tick(); start = 0;
    stall = 1; call = 1; target = 9'h077;
    repeat (2) tick();
    stall = 0; call = 0;
    check("t5_stall_pc", prog_ctr, 9'h0A0);
    check("t5_stall_d", stack_depth, 0);
    check("t5_stall_run", running, 1);
    halt = 1; ret = 1; tick(); halt = 0; ret = 0;
    check("t6_done", done, 1);
    check("t6_pc", prog_ctr, 9'h0A0);
    check("t6_err", stack_err, 0);
    start = 1; start_addr = 9'h123; tick(); start = 0;
    tick();
    stall = 1; reset = 1; start = 1; tick();
    clr();
    check("t6_rst_pc", prog_ctr, 0);
    check("t6_rst_run", running, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_d", stack_depth, 0);
    start = 1; start_addr = 9'($urandom); tick();
    for (int i = 0; i < 3000; i++) begin
      reset = $urandom_range(0, 299) == 0;
      start = $urandom_range(0, 39) == 0;
      stall = $urandom_range(0, 4) == 0;
      halt = $urandom_range(0, 59) == 0;
      ret = $urandom_range(0, 4) == 0;
      call = $urandom_range(0, 4) == 0;
      br_abs = $urandom_range(0, 3) == 0;
      br_rel = $urandom_range(0, 3) == 0;
      taken = 1'($urandom);
      target = 9'($urandom);
      start_addr = 9'($urandom);
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
